// File: rtl/simon_pattern_player.sv
// Simon-Say LED playback sequencer: lights one LED per step for ON_TICKS ticks,
// then blanks for OFF_TICKS ticks, using a prescaled tick as a clock enable.
module simon_pattern_player #(
  parameter int unsigned TICK_DIV  = 25000000,
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(MAX_LEN+1)-1:0] seq_len,
  input  logic [2*MAX_LEN-1:0]         seq_data,
  output logic [3:0]                   led,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_LEN)-1:0]   step_idx
);

  localparam int unsigned LenW  = $clog2(MAX_LEN + 1);
  localparam int unsigned IdxW  = $clog2(MAX_LEN);
  localparam int unsigned PreW  = $clog2(TICK_DIV + 1);
  localparam int unsigned MaxTk = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned TckW  = $clog2(MaxTk + 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e               r_state;
  logic [2*MAX_LEN-1:0] r_seq;
  logic [LenW-1:0]      r_len;
  logic [IdxW-1:0]      r_step;
  logic [PreW-1:0]      r_presc;
  logic [TckW-1:0]      r_tcnt;
  logic [3:0]           r_led;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_tick;
  logic                 w_last;
  logic [IdxW-1:0]      w_next_idx;
  logic [1:0]           w_next_col;
  logic [LenW-1:0]      w_len_clamp;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  assign w_tick      = (r_presc == PreW'(TICK_DIV - 1));
  assign w_last      = (LenW'(r_step) == r_len - LenW'(1));
  assign w_next_idx  = r_step + IdxW'(1);
  assign w_next_col  = r_seq[{w_next_idx, 1'b0} +: 2];
  assign w_len_clamp = (seq_len > LenW'(MAX_LEN)) ? LenW'(MAX_LEN) : seq_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_seq   <= '0;
      r_len   <= '0;
      r_step  <= '0;
      r_presc <= '0;
      r_tcnt  <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= StIdle;
        r_step  <= '0;
        r_presc <= '0;
        r_tcnt  <= '0;
        r_led   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (start) begin
              if (seq_len == '0) begin
                r_done <= 1'b1;
              end else begin
                r_seq   <= seq_data;
                r_len   <= w_len_clamp;
                r_step  <= '0;
                r_presc <= '0;
                r_tcnt  <= '0;
                r_led   <= onehot(seq_data[1:0]);
                r_busy  <= 1'b1;
                r_state <= StOn;
              end
            end
          end
          StOn: begin
            r_presc <= w_tick ? '0 : r_presc + PreW'(1);
            if (w_tick) begin
              if (r_tcnt == TckW'(ON_TICKS - 1)) begin
                r_tcnt  <= '0;
                r_led   <= '0;
                r_state <= StOff;
              end else begin
                r_tcnt <= r_tcnt + TckW'(1);
              end
            end
          end
          StOff: begin
            r_presc <= w_tick ? '0 : r_presc + PreW'(1);
            if (w_tick) begin
              if (r_tcnt == TckW'(OFF_TICKS - 1)) begin
                r_tcnt <= '0;
                if (w_last) begin
                  // busy falls in the same cycle done rises
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= StIdle;
                end else begin
                  r_step  <= w_next_idx;
                  r_led   <= onehot(w_next_col);
                  r_state <= StOn;
                end
              end else begin
                r_tcnt <= r_tcnt + TckW'(1);
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign led      = r_led;
  assign busy     = r_busy;
  assign done     = r_done;
  assign step_idx = r_step;

endmodule

// File: tb/tb_simon_pattern_player.sv
// Directed bench for simon_pattern_player with TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, MAX_LEN=8.
module tb_simon_pattern_player;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  seq_len;
  logic [15:0] seq_data;
  logic [3:0]  led;
  logic        busy;
  logic        done;
  logic [2:0]  step_idx;

  int checks;
  int failures;

  simon_pattern_player #(
    .TICK_DIV (4),
    .MAX_LEN  (8),
    .ON_TICKS (2),
    .OFF_TICKS(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .seq_len (seq_len),
    .seq_data(seq_data),
    .led     (led),
    .busy    (busy),
    .done    (done),
    .step_idx(step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, ".led"}, 32'(led), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask

  // Plays one sequence and checks every cycle against a 12-cycle-per-step model.
  task automatic run_seq(input string tag, input logic [3:0] len_in, input logic [15:0] data,
                         input bit disturb);
    int n;
    int s;
    int nbusy;
    logic [1:0] col;
    logic [3:0] exp_led;
    n = (len_in > 8) ? 8 : int'(len_in);
    nbusy = 0;
    seq_len = len_in;
    seq_data = data;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < n * 12; c++) begin
      s = c / 12;
      col = data[2*s +: 2];
      exp_led = ((c % 12) < 8) ? (4'b0001 << col) : 4'b0000;
      if (busy) nbusy++;
      chk($sformatf("%s.led[%0d]", tag, c), 32'(led), 32'(exp_led));
      chk($sformatf("%s.busy[%0d]", tag, c), 32'(busy), 32'h1);
      chk($sformatf("%s.step[%0d]", tag, c), 32'(step_idx), 32'(s));
      chk($sformatf("%s.done[%0d]", tag, c), 32'(done), 32'h0);
      if (disturb && c == 5) begin
        start = 1'b1;
        seq_data = ~data;
        seq_len = 4'd1;
      end
      if (disturb && c == 6) start = 1'b0;
      cyc();
    end
    chk({tag, ".nbusy"}, 32'(nbusy), 32'(n * 12));
    chk_idle({tag, ".end"}, 1'b1);
    cyc();
    chk_idle({tag, ".after"}, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    seq_len = '0;
    seq_data = '0;
    cyc();
    cyc();
    chk_idle("reset", 1'b0);
    chk("reset.step", 32'(step_idx), 32'h0);
    rst_n = 1'b1;
    cyc();
    chk_idle("post_reset", 1'b0);

    // Basic playback: colours {0,2,3}
    run_seq("basic", 4'd3, 16'h0038, 1'b0);

    // Empty sequence
    seq_len = 4'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk_idle("empty.pulse", 1'b1);
    cyc();
    chk_idle("empty.after", 1'b0);

    // Length clamp: 15 -> 8 steps, colours 0,1,2,3,3,2,1,0
    run_seq("clamp", 4'd15, 16'h1BE4, 1'b0);

    // Abort mid-ON of step 0 (led lit)
    seq_len = 4'd3;
    seq_data = 16'h0038;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    chk("abort.pre_led", 32'(led), 32'h1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_idle("abort.now", 1'b0);
    chk("abort.step", 32'(step_idx), 32'h0);
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk_idle($sformatf("abort.quiet[%0d]", i), 1'b0);
    end

    // Abort during OFF at cycle 10, then replay from step 0
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (10) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_idle("abort2.now", 1'b0);
    run_seq("replay", 4'd3, 16'h0038, 1'b0);

    // start and abort together in IDLE: abort wins
    seq_len = 4'd3;
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk_idle("start_abort", 1'b0);
    cyc();
    chk_idle("start_abort.next", 1'b0);

    // Ignored start and seq_data/seq_len changes mid-run
    run_seq("ignore", 4'd3, 16'h0027, 1'b1);

    // Asynchronous reset during ON of step 1
    seq_len = 4'd3;
    seq_data = 16'h0038;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (14) cyc();
    chk("rst.pre_led", 32'(led), 32'h4);
    chk("rst.pre_step", 32'(step_idx), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst.async", 1'b0);
    chk("rst.step", 32'(step_idx), 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk_idle("rst.release", 1'b0);
    run_seq("after_rst", 4'd2, 16'h000D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
